// File: rtl/master_slave_relay_n_pkg.sv
// Shared types and the width-generic combine function for the round-robin relay.
// Callers sign-extend operands to COMBINE_MAX_W and truncate the result back.
package master_slave_relay_n_types;

    localparam int unsigned COMBINE_MAX_W = 64;

    typedef enum logic {SECTION_A, SECTION_B} sections;

    typedef enum logic [1:0] {PASS, ACC, MAX, XOR} combine_mode_t;

    typedef logic [COMBINE_MAX_W-1:0] combine_word_t;

    // Sign-extended operands keep the signed MAX correct; low bits of the others are unaffected.
    function automatic combine_word_t combine(input combine_word_t val_w,
                                              input combine_word_t in_w,
                                              input combine_mode_t   mode);
        combine_word_t res;
        case (mode)
            PASS:    res = in_w;
            ACC:     res = val_w + in_w;
            MAX:     res = ($signed(val_w) > $signed(in_w)) ? val_w : in_w;
            XOR:     res = val_w ^ in_w;
            default: res = in_w;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/master_slave_relay_n_if.sv
// Slave-channel inputs and master result outputs of the relay.
// master: producer/consumer side; slave: the relay itself.
interface master_slave_relay_n_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned NUM_CH = 4
);
    localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [NUM_CH-1:0][DATA_W-1:0] s_in;
    logic [NUM_CH-1:0]             s_in_sync;
    logic [1:0]                    mode;
    logic [DATA_W-1:0]             s_out;
    logic                          s_out_valid;
    logic [CH_W-1:0]               s_out_ch;
    logic                          busy;

    modport master (
        output s_in, s_in_sync, mode,
        input  s_out, s_out_valid, s_out_ch, busy
    );

    modport slave (
        input  s_in, s_in_sync, mode,
        output s_out, s_out_valid, s_out_ch, busy
    );

endinterface

// File: rtl/master_slave_relay_n_combine.sv
// Combinational DATA_W-wide ALU for the four combine modes.
module relay_combine
    import master_slave_relay_n_types::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic [DATA_W-1:0] val_i,
    input  logic [DATA_W-1:0] in_i,
    input  combine_mode_t     mode_i,
    output logic [DATA_W-1:0] res_c
);

    combine_word_t wide;

    always_comb begin
        wide  = combine(COMBINE_MAX_W'($signed(val_i)), COMBINE_MAX_W'($signed(in_i)), mode_i);
        res_c = DATA_W'(wide);
    end

endmodule

// File: rtl/master_slave_relay_n.sv
// Round-robin relay: polls one slave channel at a time, combines the synced word
// into val, and publishes it on the master side with a one-cycle valid pulse.
module master_slave_relay_n
    import master_slave_relay_n_types::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned NUM_CH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    master_slave_relay_n_if.slave bus
);

    localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    sections           section_q, section_d;
    logic [CH_W-1:0]   ch_q, ch_d, ch_next;
    logic [CH_W-1:0]   cap_ch_q, cap_ch_d;
    logic [CH_W-1:0]   s_out_ch_q, s_out_ch_d;
    logic [DATA_W-1:0] val_q, val_d;
    logic [DATA_W-1:0] s_out_q, s_out_d;
    logic              s_out_valid_q, s_out_valid_d;
    logic              busy_q, busy_d;
    logic [DATA_W-1:0] sel_data, comb_res;
    logic              sel_sync;

    // Only the pointed-at channel is visible; all other syncs are ignored.
    always_comb begin
        sel_data = '0;
        sel_sync = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (ch_q == CH_W'(c)) begin
                sel_data = bus.s_in[c];
                sel_sync = bus.s_in_sync[c];
            end
        end
        ch_next = (ch_q == CH_W'(NUM_CH - 1)) ? '0 : ch_q + CH_W'(1);
    end

    relay_combine #(.DATA_W(DATA_W)) u_combine (
        .val_i  (val_q),
        .in_i   (sel_data),
        .mode_i (combine_mode_t'(bus.mode)),
        .res_c  (comb_res)
    );

    always_comb begin
        section_d     = section_q;
        ch_d          = ch_q;
        cap_ch_d      = cap_ch_q;
        val_d         = val_q;
        s_out_d       = s_out_q;
        s_out_ch_d    = s_out_ch_q;
        s_out_valid_d = 1'b0;
        case (section_q)
            SECTION_A: begin
                if (sel_sync) begin
                    val_d     = comb_res;
                    cap_ch_d  = ch_q;
                    ch_d      = ch_next;
                    section_d = SECTION_B;
                end
            end
            SECTION_B: begin
                s_out_d       = val_q;
                s_out_ch_d    = cap_ch_q;
                s_out_valid_d = 1'b1;
                section_d     = SECTION_A;
            end
            default: section_d = SECTION_A;
        endcase
        busy_d = (section_d == SECTION_B);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            section_q     <= SECTION_A;
            ch_q          <= '0;
            cap_ch_q      <= '0;
            val_q         <= '0;
            s_out_q       <= '0;
            s_out_ch_q    <= '0;
            s_out_valid_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            section_q     <= section_d;
            ch_q          <= ch_d;
            cap_ch_q      <= cap_ch_d;
            val_q         <= val_d;
            s_out_q       <= s_out_d;
            s_out_ch_q    <= s_out_ch_d;
            s_out_valid_q <= s_out_valid_d;
            busy_q        <= busy_d;
        end
    end

    assign bus.s_out       = s_out_q;
    assign bus.s_out_valid = s_out_valid_q;
    assign bus.s_out_ch    = s_out_ch_q;
    assign bus.busy        = busy_q;

endmodule

// File: tb/tb_master_slave_relay_n.sv
// Scenario bench for master_slave_relay_n (DATA_W=8, NUM_CH=4) with an expected-result queue.
module tb_master_slave_relay_n;

    logic clk;
    logic rst;

    master_slave_relay_n_if #(.DATA_W(8), .NUM_CH(4)) bus ();

    master_slave_relay_n #(.DATA_W(8), .NUM_CH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [7:0] d;
        logic [1:0] ch;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset(input int n);
        rst = 1'b1;
        bus.s_in_sync = '0;
        repeat (n) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_pulse(input int budget, output bit got, output logic [7:0] d,
                              output logic [1:0] c, output int waited);
        got = 1'b0; d = 'x; c = 'x; waited = 0;
        for (int i = 1; i <= budget && !got; i++) begin
            @(negedge clk);
            waited = i;
            if (bus.s_out_valid === 1'b1) begin
                got = 1'b1;
                d   = bus.s_out;
                c   = bus.s_out_ch;
            end
        end
    endtask

    task automatic count_pulses(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (bus.s_out_valid !== 1'b0) cnt++;
        end
    endtask

    // Raise sync on one channel, wait for the pulse, then release the sync.
    task automatic serve(input int ch, input logic [7:0] data, output bit got,
                         output logic [7:0] d, output logic [1:0] c);
        int waited;
        bus.s_in[ch]      = data;
        bus.s_in_sync[ch] = 1'b1;
        wait_pulse(6, got, d, c, waited);
        bus.s_in_sync[ch] = 1'b0;
    endtask

    task automatic test_reset();
        bit got; logic [7:0] d; logic [1:0] c; int waited, cnt;
        exp_t e;
        bus.mode = 2'b00;
        bus.s_in = '0;
        do_reset(2);
        n_cmp++; if (bus.s_out !== 8'd0) begin n_err++; $display("FAIL reset_s_out: got %0d want 0", bus.s_out); end
        n_cmp++; if (bus.s_out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", bus.s_out_valid); end
        n_cmp++; if (bus.s_out_ch !== 2'd0) begin n_err++; $display("FAIL reset_ch: got %0d want 0", bus.s_out_ch); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        // Capture on channel 0, then reset while in SECTION_B.
        bus.s_in[0] = 8'd99;
        bus.s_in_sync[0] = 1'b1;
        @(negedge clk);
        n_cmp++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL busy_in_b: got %b want 1", bus.busy); end
        rst = 1'b1;
        bus.s_in_sync = '0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_cmp++; if (bus.s_out_valid !== 1'b0) begin n_err++; $display("FAIL midb_reset_valid: got %b want 0", bus.s_out_valid); end
        end
        n_cmp++; if (bus.s_out !== 8'd0 || bus.s_out_ch !== 2'd0 || bus.busy !== 1'b0) begin
            n_err++; $display("FAIL midb_reset_state: got s_out=%0d ch=%0d busy=%b want 0/0/0", bus.s_out, bus.s_out_ch, bus.busy);
        end
        rst = 1'b0;
        count_pulses(4, cnt);
        n_cmp++; if (cnt != 0) begin n_err++; $display("FAIL midb_no_pulse: got %0d pulses want 0", cnt); end
        for (int k = 0; k < 4; k++) bus.s_in[k] = 8'(k + 1);
        bus.s_in_sync = '1;
        sb.push_back('{d: 8'd1, ch: 2'd0});
        wait_pulse(4, got, d, c, waited);
        bus.s_in_sync = '0;
        e = sb.pop_front();
        n_cmp++; if (!got || d !== e.d || c !== e.ch) begin
            n_err++; $display("FAIL after_reset_ch0: got valid=%b data=%0d ch=%0d want data=%0d ch=%0d", got, d, c, e.d, e.ch);
        end
    endtask

    task automatic test_pass_rr();
        bit got; logic [7:0] d; logic [1:0] c; int waited;
        exp_t e;
        do_reset(1);
        bus.mode = 2'b00;
        for (int k = 0; k < 4; k++) bus.s_in[k] = 8'(10 * (k + 1));
        bus.s_in_sync = '1;
        for (int k = 0; k < 5; k++) sb.push_back('{d: 8'(10 * ((k % 4) + 1)), ch: 2'(k % 4)});
        for (int k = 0; k < 5; k++) begin
            wait_pulse(4, got, d, c, waited);
            e = sb.pop_front();
            n_cmp++; if (!got || d !== e.d || c !== e.ch) begin
                n_err++; $display("FAIL pass_rr[%0d]: got valid=%b data=%0d ch=%0d want data=%0d ch=%0d", k, got, d, c, e.d, e.ch);
            end
            n_cmp++; if (waited != 2) begin
                n_err++; $display("FAIL pass_rr_spacing[%0d]: got %0d cycles want 2", k, waited);
            end
        end
        bus.s_in_sync = '0;
    endtask

    task automatic test_strict_order();
        bit got; logic [7:0] d; logic [1:0] c; int cnt;
        exp_t e;
        do_reset(1);
        bus.mode = 2'b00;
        bus.s_in[2] = 8'd77;
        bus.s_in_sync[2] = 1'b1;
        count_pulses(10, cnt);
        n_cmp++; if (cnt != 0) begin n_err++; $display("FAIL order_skip: got %0d pulses want 0", cnt); end
        sb.push_back('{d: 8'd5, ch: 2'd0});
        serve(0, 8'd5, got, d, c);
        e = sb.pop_front();
        n_cmp++; if (!got || d !== e.d || c !== e.ch) begin
            n_err++; $display("FAIL order_ch0: got valid=%b data=%0d ch=%0d want data=%0d ch=%0d", got, d, c, e.d, e.ch);
        end
        count_pulses(10, cnt);
        n_cmp++; if (cnt != 0) begin n_err++; $display("FAIL order_ptr1: got %0d pulses want 0", cnt); end
        bus.s_in_sync = '0;
    endtask

    task automatic test_acc_wrap();
        bit got; logic [7:0] d; logic [1:0] c;
        exp_t e;
        logic [7:0] din [2] = '{8'd200, 8'd100};
        logic [7:0] want[2] = '{8'd200, 8'd44};
        do_reset(1);
        bus.mode = 2'b01;
        for (int k = 0; k < 2; k++) begin
            sb.push_back('{d: want[k], ch: 2'(k)});
            serve(k, din[k], got, d, c);
            e = sb.pop_front();
            n_cmp++; if (!got || d !== e.d || c !== e.ch) begin
                n_err++; $display("FAIL acc_wrap[%0d]: got valid=%b data=%0d ch=%0d want data=%0d ch=%0d", k, got, d, c, e.d, e.ch);
            end
        end
    endtask

    task automatic test_max_signed();
        bit got; logic [7:0] d; logic [1:0] c;
        exp_t e;
        logic [7:0] din [3] = '{8'h05, 8'hF0, 8'h7F};
        logic [7:0] want[3] = '{8'h05, 8'h05, 8'h7F};
        do_reset(1);
        bus.mode = 2'b10;
        for (int k = 0; k < 3; k++) begin
            sb.push_back('{d: want[k], ch: 2'(k)});
            serve(k, din[k], got, d, c);
            e = sb.pop_front();
            n_cmp++; if (!got || d !== e.d || c !== e.ch) begin
                n_err++; $display("FAIL max_signed[%0d]: got valid=%b data=%h ch=%0d want data=%h ch=%0d", k, got, d, c, e.d, e.ch);
            end
        end
    endtask

    task automatic test_mode_switch();
        bit got; logic [7:0] d; logic [1:0] c; int waited;
        exp_t e;
        do_reset(1);
        bus.mode = 2'b00;
        bus.s_in[0] = 8'hA5;
        bus.s_in_sync[0] = 1'b1;
        sb.push_back('{d: 8'hA5, ch: 2'd0});
        @(negedge clk);
        // Now in SECTION_B: a mode change here must not alter the pending result.
        bus.mode = 2'b01;
        bus.s_in_sync[0] = 1'b0;
        wait_pulse(3, got, d, c, waited);
        e = sb.pop_front();
        n_cmp++; if (!got || d !== e.d || c !== e.ch) begin
            n_err++; $display("FAIL mode_pass: got valid=%b data=%h ch=%0d want data=%h ch=%0d", got, d, c, e.d, e.ch);
        end
        bus.mode = 2'b11;
        sb.push_back('{d: 8'h5A, ch: 2'd1});
        serve(1, 8'hFF, got, d, c);
        e = sb.pop_front();
        n_cmp++; if (!got || d !== e.d || c !== e.ch) begin
            n_err++; $display("FAIL mode_xor: got valid=%b data=%h ch=%0d want data=%h ch=%0d", got, d, c, e.d, e.ch);
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.s_in = '0;
        bus.s_in_sync = '0;
        bus.mode = 2'b00;
        test_reset();
        test_pass_rr();
        test_strict_order();
        test_acc_wrap();
        test_max_signed();
        test_mode_switch();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
